hist_collect: RTL and testbench

//  Histogram sink for the component stream produced by the histogram source selector.

---
 rtl/hist_pkg.sv | 14 +
 rtl/hist_collect_ram.sv | 38 +++
 rtl/hist_collect.sv | 191 +++++++++++++++++++
 tb/tb_hist_collect.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared widths and FSM state type for the histogram collector.
package hist_pkg;

  localparam int unsigned HIST_PIX_W = 8;
  localparam int unsigned HIST_CNT_W = 20;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DUMP  = 2'd3
  } hist_state_t;

endpackage

// File: rtl/hist_collect_ram.sv
// Bin storage: simple dual-port RAM, one write port and one registered read port.
module hist_collect_ram
  import hist_pkg::*;
#(
  parameter int unsigned ADDR_W = HIST_PIX_W,
  parameter int unsigned DATA_W = HIST_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; array contents are not reset, the CLEAR sweep initialises them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; the output register holds its value while re is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/hist_collect.sv
// Frame histogram sink: counts component values per frame, then streams and clears every bin.
module hist_collect
  import hist_pkg::*;
#(
  parameter int unsigned PIX_W = HIST_PIX_W,
  parameter int unsigned CNT_W = HIST_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_comp,
  input  logic             in_frame_end,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [PIX_W-1:0] rd_bin,
  output logic [CNT_W-1:0] rd_count,
  output logic             rd_last,
  output logic             busy,
  output logic             dropped
);

  localparam int unsigned PTR_W = PIX_W + 1;
  localparam logic [PIX_W-1:0] LAST_BIN = {PIX_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  hist_state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PIX_W-1:0] rd_bin_q, rd_bin_d;
  logic             rd_last_q, rd_last_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  logic             s2_valid_q;
  logic [PIX_W-1:0] s2_bin_q;
  logic             fwd_hit_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  logic             s1_fire;
  logic [CNT_W-1:0] s2_old, s2_new;

  logic             ram_we, ram_re;
  logic [PIX_W-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;

  logic             rd_hs, dump_issue, accum_entry, drop_evt;

  hist_collect_ram #(
    .ADDR_W (PIX_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re      (ram_re),
    .raddr   (ram_raddr),
    .rdata   (ram_rdata)
  );

  // Increment stage: take the forwarded value when the previous write hit the same bin.
  always_comb begin
    s1_fire = (state_q == ACCUM) && in_valid;
    s2_old  = fwd_hit_q ? fwd_cnt_q : ram_rdata;
    s2_new  = (s2_old == CNT_MAX) ? s2_old : s2_old + CNT_W'(1);
  end

  // Next-state, RAM port control and output register next values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = rd_valid_q;
    rd_bin_d   = rd_bin_q;
    rd_last_d  = rd_last_q;
    ram_we     = 1'b0;
    ram_waddr  = s2_bin_q;
    ram_wdata  = s2_new;
    ram_re     = 1'b0;
    ram_raddr  = in_comp;
    rd_hs      = 1'b0;
    dump_issue = 1'b0;

    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q[PIX_W-1:0];
        ram_wdata = '0;
        if (ptr_q[PIX_W-1:0] == LAST_BIN) begin
          state_d = ACCUM;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      ACCUM: begin
        ram_re    = in_valid;
        ram_raddr = in_comp;
        ram_we    = s2_valid_q;
        if (in_frame_end) begin
          state_d = DRAIN;
          ptr_d   = '0;
        end
      end
      DRAIN: begin
        ram_we = s2_valid_q;
        if (ptr_q[0]) begin
          state_d = DUMP;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      DUMP: begin
        rd_hs      = rd_valid_q && rd_ready;
        dump_issue = !ptr_q[PIX_W] && (!rd_valid_q || rd_ready);
        if (rd_hs) begin
          ram_we     = 1'b1;
          ram_waddr  = rd_bin_q;
          ram_wdata  = '0;
          rd_valid_d = 1'b0;
        end
        if (dump_issue) begin
          ram_re     = 1'b1;
          ram_raddr  = ptr_q[PIX_W-1:0];
          rd_valid_d = 1'b1;
          rd_bin_d   = ptr_q[PIX_W-1:0];
          rd_last_d  = (ptr_q[PIX_W-1:0] == LAST_BIN);
          ptr_d      = ptr_q + PTR_W'(1);
        end
        if (rd_hs && rd_last_q) begin
          state_d   = ACCUM;
          rd_last_d = 1'b0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase

    busy_d      = (state_d != ACCUM);
    accum_entry = (state_d == ACCUM) && (state_q != ACCUM);
    drop_evt    = (state_q != ACCUM) && (in_valid || in_frame_end);
    dropped_d   = accum_entry ? 1'b0 : (dropped_q || drop_evt);
  end

  // FSM state, pointer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_bin_q   <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b1;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_bin_q   <= rd_bin_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  // Read-modify-write pipeline registers and same-bin forwarding capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_cnt_q  <= '0;
    end else begin
      s2_valid_q <= s1_fire;
      s2_bin_q   <= in_comp;
      fwd_hit_q  <= s1_fire && s2_valid_q && (s2_bin_q == in_comp);
      fwd_cnt_q  <= s2_new;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_bin   = rd_bin_q;
  assign rd_count = ram_rdata;
  assign rd_last  = rd_last_q;
  assign busy     = busy_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_hist_collect.sv
// Self-checking bench for hist_collect: two instances (CNT_W=20 and CNT_W=4) share all inputs.
module tb_hist_collect;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_comp;
  logic       in_frame_end;
  logic       rd_ready;

  logic        rd_valid, rd_last, busy, dropped;
  logic [7:0]  rd_bin;
  logic [19:0] rd_count;
  logic        b_valid, b_last, b_busy, b_dropped;
  logic [7:0]  b_bin;
  logic [3:0]  b_count;

  int checks   = 0;
  int failures = 0;

  int unsigned model [256];
  int          cap_a [256];
  int          cap_b [256];

  typedef struct {
    int frame;
    int comp;
    int n;
    bit fe_same;
    int exp_a;
    int exp_b;
  } row_t;

  localparam int NROWS = 10;
  row_t tbl [NROWS];

  always #5 clk = ~clk;

  hist_collect #(.PIX_W(8), .CNT_W(20)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_comp(in_comp),
    .in_frame_end(in_frame_end), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_bin(rd_bin), .rd_count(rd_count), .rd_last(rd_last), .busy(busy), .dropped(dropped)
  );

  hist_collect #(.PIX_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_comp(in_comp),
    .in_frame_end(in_frame_end), .rd_valid(b_valid), .rd_ready(rd_ready),
    .rd_bin(b_bin), .rd_count(b_count), .rd_last(b_last), .busy(b_busy), .dropped(b_dropped)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat(input int unsigned v, input int w);
    longint m;
    m = (64'sd1 <<< w) - 1;
    return (longint'(v) > m) ? m : longint'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid     = 1'b0;
    in_comp      = 8'd0;
    in_frame_end = 1'b0;
  endtask

  // Reset both instances, check reset outputs, then time the CLEAR sweep.
  task automatic reset_and_clear();
    int  n;
    logic seen_valid;
    reset_n  = 1'b0;
    rd_ready = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs",  64'({rd_valid, rd_bin, rd_count, rd_last, dropped}), 64'd0);
    chk("rst_busy",  64'(busy), 64'd1);
    chk("rst_outs4", 64'({b_valid, b_bin, b_count, b_last, b_dropped}), 64'd0);
    chk("rst_busy4", 64'(b_busy), 64'd1);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 0;
    n = 0;
    seen_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (rd_valid || b_valid) seen_valid = 1'b1;
      if (!busy) break;
      n++;
    end
    chk("clear_busy_cycles", 64'(n), 64'd256);
    chk("valid_during_clear", 64'(seen_valid), 64'd0);
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      step();
    end
    chk("idle_before_frame", 64'(busy), 64'd0);
  endtask

  // Send all table rows of one frame back-to-back, then end the frame.
  task automatic send_frame(input int f);
    int last_r;
    last_r = 0;
    for (int r = 0; r < NROWS; r++) if (tbl[r].frame == f) last_r = r;
    wait_idle();
    for (int r = 0; r < NROWS; r++) begin
      if (tbl[r].frame == f) begin
        for (int k = 0; k < tbl[r].n; k++) begin
          in_valid     = 1'b1;
          in_comp      = 8'(tbl[r].comp);
          in_frame_end = (r == last_r) && (k == tbl[r].n - 1) && tbl[r].fe_same;
          model[tbl[r].comp]++;
          step();
        end
      end
    end
    clear_inputs();
    if (!tbl[last_r].fe_same) begin
      in_frame_end = 1'b1;
      step();
      in_frame_end = 1'b0;
    end
  endtask

  // Random frame with gaps and clustered values; frame_end rides on the last cycle.
  task automatic send_random(input int n);
    wait_idle();
    for (int k = 0; k < n; k++) begin
      in_valid     = ($urandom_range(3) != 0);
      in_comp      = ($urandom_range(1) == 1) ? 8'($urandom_range(7)) : 8'($urandom_range(255));
      in_frame_end = (k == n - 1);
      if (in_valid) model[in_comp]++;
      step();
    end
    clear_inputs();
  endtask

  // Drain a dump with optional backpressure, optional busy-time injection, optional abort.
  task automatic run_dump(input int pct_low, input bit inject, input int abort_at,
                          output int beats, output int first_cyc);
    logic        stalled;
    logic [43:0] hold;
    beats     = 0;
    first_cyc = -1;
    stalled   = 1'b0;
    hold      = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rd_ready = (int'($urandom_range(99)) >= pct_low);
      if (inject && cyc < 6) begin
        in_valid     = 1'b1;
        in_comp      = 8'd9;
        in_frame_end = (cyc == 3);
      end else begin
        clear_inputs();
      end
      @(negedge clk);
      if (rd_valid && first_cyc < 0) first_cyc = cyc;
      if (stalled)
        chk("stall_hold", 64'({rd_valid, rd_bin, rd_last, rd_count, b_valid, b_bin, b_last, b_count}),
            64'(hold));
      if (rd_valid && rd_ready) begin
        chk("beat_bin",   64'(rd_bin),   64'(beats));
        chk("beat_count", 64'(rd_count), sat(model[beats], 20));
        chk("beat_count4", 64'(b_count), sat(model[beats], 4));
        chk("beat_last",  64'(rd_last),  64'(beats == 255));
        chk("beat_b",     64'({b_valid, b_bin, b_last}), 64'({1'b1, 8'(beats), beats == 255}));
        cap_a[beats] = int'(rd_count);
        cap_b[beats] = int'(b_count);
        model[beats] = 0;
        beats++;
      end
      stalled = rd_valid && !rd_ready;
      hold    = {rd_valid, rd_bin, rd_last, rd_count, b_valid, b_bin, b_last, b_count};
      if (inject && cyc == 20)
        chk("dropped_in_dump", 64'({dropped, b_dropped}), 64'd3);
      if (beats == 256 || (abort_at > 0 && beats == abort_at)) break;
      @(posedge clk);
      #1;
    end
    clear_inputs();
    if (abort_at > 0) begin
      chk("abort_beats", 64'(beats), 64'(abort_at));
    end else begin
      chk("dump_beats", 64'(beats), 64'd256);
      step();
      rd_ready = 1'b0;
      chk("post_dump", 64'({busy, rd_valid, rd_last, dropped}), 64'd0);
    end
  endtask

  task automatic check_table(input int f, input int beats);
    for (int r = 0; r < NROWS; r++) begin
      if (tbl[r].frame == f && tbl[r].comp < beats) begin
        chk("tbl_count",  64'(cap_a[tbl[r].comp]), 64'(tbl[r].exp_a));
        chk("tbl_count4", 64'(cap_b[tbl[r].comp]), 64'(tbl[r].exp_b));
      end
    end
  endtask

  task automatic check_latency(input int first_cyc);
    checks++;
    if (first_cyc < 0 || first_cyc > 3) begin
      failures++;
      $display("FAIL first_valid_latency: got %0d expected at most 3", first_cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, first_cyc;
    tbl[0] = '{0, 5,   10, 1'b0, 10, 10};
    tbl[1] = '{0, 200, 3,  1'b0, 3,  3};
    tbl[2] = '{1, 7,   2,  1'b0, 3,  3};
    tbl[3] = '{1, 8,   1,  1'b0, 1,  1};
    tbl[4] = '{1, 7,   1,  1'b1, 3,  3};
    tbl[5] = '{3, 9,   2,  1'b0, 2,  2};
    tbl[6] = '{3, 1,   20, 1'b0, 20, 15};
    tbl[7] = '{3, 250, 4,  1'b1, 4,  4};
    tbl[8] = '{4, 3,   1,  1'b0, 1,  1};
    tbl[9] = '{4, 250, 1,  1'b1, 1,  1};

    reset_and_clear();

    send_frame(0);
    run_dump(0, 1'b0, 0, beats, first_cyc);
    check_latency(first_cyc);
    check_table(0, beats);

    send_frame(1);
    run_dump(0, 1'b0, 0, beats, first_cyc);
    check_latency(first_cyc);
    check_table(1, beats);

    send_random(300);
    run_dump(30, 1'b1, 0, beats, first_cyc);
    check_latency(first_cyc);

    send_frame(3);
    run_dump(0, 1'b0, 100, beats, first_cyc);
    check_table(3, beats);
    chk("pre_abort_valid", 64'(rd_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_outs", 64'({rd_valid, rd_last, rd_count, b_valid, b_count}), 64'd0);
    chk("abort_busy", 64'({busy, b_busy}), 64'd3);
    reset_and_clear();

    send_frame(4);
    run_dump(30, 1'b0, 0, beats, first_cyc);
    check_table(4, beats);

    send_random(400);
    run_dump(30, 1'b0, 0, beats, first_cyc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
